// File: rtl/disp_arb_pkg.sv
// rtl/disp_arb_pkg.sv - shared encodings and widths for the display arbiter
package disp_arb_pkg;

    localparam int NREQ    = 4;
    localparam int DIGIT_W = 16;
    localparam int DP_W    = 4;
    localparam int TIMER_W = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHARE = 2'd2
    } state_t;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/disp_arbiter_if.sv
// rtl/disp_arbiter_if.sv - requester/display bundle between clients and the arbiter
interface disp_arbiter_if;
    import disp_arb_pkg::*;

    logic [NREQ-1:0]         req;
    logic [NREQ*DIGIT_W-1:0] val_in;
    logic [NREQ*DP_W-1:0]    dp_in;
    logic [NREQ-1:0]         gnt;
    logic [1:0]              owner;
    logic [DIGIT_W-1:0]      hex_out;
    logic [DP_W-1:0]         dp_out;
    logic                    busy;

    modport master (
        output req, val_in, dp_in,
        input  gnt, owner, hex_out, dp_out, busy
    );

    modport slave (
        input  req, val_in, dp_in,
        output gnt, owner, hex_out, dp_out, busy
    );
endinterface

// File: rtl/disp_arbiter_rr_pick.sv
// rtl/disp_arbiter_rr_pick.sv - combinational round-robin picker starting at a given index
module rr_pick
    import disp_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      start,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      idx,
    output logic            valid
);

    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest asserted requester wins.
    always_comb begin
        gnt   = '0;
        idx   = start;
        valid = 1'b0;
        cand  = start;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = start + 2'(k);
            if (req[cand]) begin
                gnt        = '0;
                gnt[cand]  = 1'b1;
                idx        = cand;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - display mux arbiter with dwell timer; DISP_ARB_PRIO0_EN adds requester-0 preemption
module disp_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    disp_arbiter_if.slave  bus
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(HOLD_CYC - 1);

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [1:0]          owner_q, owner_d;
    logic [DIGIT_W-1:0]  hex_q, hex_d;
    logic [DP_W-1:0]     dp_q, dp_d;
    logic                busy_q;

    logic [NREQ-1:0]     pick_gnt;
    logic [1:0]          pick_idx;
    logic                pick_valid;
    logic                others;
    logic                show;

    rr_pick u_pick (
        .req   (bus.req),
        .start (next_idx(owner_q)),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign others = |(bus.req & ~gnt_q);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d = HOLD;
                    timer_d = RELOAD;
                    gnt_d   = pick_gnt;
                    owner_d = pick_idx;
                end
            end
            HOLD, SHARE: begin
                // Owner release beats everything; a pending request is granted from IDLE.
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    timer_d = '0;
                    gnt_d   = '0;
                end
`ifdef DISP_ARB_PRIO0_EN
                else if (bus.req[0] && owner_q != 2'd0) begin
                    state_d = HOLD;
                    timer_d = RELOAD;
                    gnt_d   = 4'b0001;
                    owner_d = 2'd0;
                end
`endif
                else if (state_q == SHARE) begin
                    if (others) begin
                        state_d = HOLD;
                        timer_d = RELOAD;
                        gnt_d   = pick_gnt;
                        owner_d = pick_idx;
                    end
                end else if (timer_q == '0) begin
                    state_d = SHARE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // Display follows the holder of the current cycle, blanked whenever we leave or sit in IDLE.
    assign show  = (state_q != IDLE) && (state_d != IDLE);
    assign hex_d = show ? bus.val_in[{owner_q, 4'b0000} +: DIGIT_W] : '0;
    assign dp_d  = show ? bus.dp_in[{owner_q, 2'b00} +: DP_W] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            gnt_q   <= '0;
            owner_q <= 2'd3;
            hex_q   <= '0;
            dp_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.owner   = owner_q;
    assign bus.hex_out = hex_q;
    assign bus.dp_out  = dp_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// tb/tb_disp_arbiter.sv - directed and random checks of disp_arbiter against a tenure-count model
module tb_disp_arbiter;
    import disp_arb_pkg::*;

    localparam int HC = 4;
`ifdef DISP_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disp_arbiter_if bus();

    disp_arbiter #(.HOLD_CYC(HC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: who holds the display, who held it last, and how many cycles it has been shown.
    int          holder;
    int          last;
    int          held;
    logic [15:0] e_hex;
    logic [3:0]  e_dp;

    function automatic int rr(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        holder = -1;
        last   = 3;
        held   = 0;
        e_hex  = '0;
        e_dp   = '0;
    endtask

    task automatic model_edge();
        logic [3:0] r;
        logic [3:0] mine;
        int nxt;
        r = bus.req;
        if (holder < 0) begin
            e_hex = '0;
            e_dp  = '0;
            nxt = rr(r, (last + 1) % 4);
            if (nxt >= 0) begin
                holder = nxt;
                last   = nxt;
                held   = 1;
            end
        end else if (!r[holder]) begin
            holder = -1;
            e_hex  = '0;
            e_dp   = '0;
        end else begin
            e_hex = bus.val_in[holder*16 +: 16];
            e_dp  = bus.dp_in[holder*4 +: 4];
            mine  = '0;
            mine[holder] = 1'b1;
            if (PRIO0 && holder != 0 && r[0]) begin
                holder = 0;
                last   = 0;
                held   = 1;
            end else if (held > HC && (r & ~mine) != 4'b0000) begin
                nxt    = rr(r, (holder + 1) % 4);
                holder = nxt;
                last   = nxt;
                held   = 1;
            end else begin
                held++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        eg = '0;
        if (holder >= 0) eg[holder] = 1'b1;
        check({tag, ".gnt"},     32'(bus.gnt),     32'(eg));
        check({tag, ".owner"},   32'(bus.owner),   32'(last));
        check({tag, ".busy"},    32'(bus.busy),    32'(holder >= 0));
        check({tag, ".hex"},     32'(bus.hex_out), 32'(e_hex));
        check({tag, ".dp"},      32'(bus.dp_out),  32'(e_dp));
        check({tag, ".onehot"},  32'($onehot0(bus.gnt)), 32'd1);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset      = 1'b0;
        bus.req    = '0;
        bus.val_in = '0;
        bus.dp_in  = '0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.owner3", 32'(bus.owner), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        cycle("idle");

        // Single requester: grant after one cycle, digits one cycle later.
        bus.req          = 4'b0001;
        bus.val_in[15:0] = 16'h1234;
        bus.dp_in[3:0]   = 4'b0100;
        cycle("first_gnt");
        check("first_gnt.g", 32'(bus.gnt), 32'h1);
        cycle("first_hex");
        check("first_hex.h", 32'(bus.hex_out), 32'h1234);
        check("first_hex.d", 32'(bus.dp_out), 32'h4);

        bus.req = 4'b0011;
        for (int i = 0; i < 12; i++) cycle("share01");
        bus.req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drop");

        bus.req = 4'b1111;
        bus.val_in = 64'h4444_3333_2222_1111;
        bus.dp_in  = 16'h8421;
        for (int i = 0; i < 25; i++) cycle("rr_all");
        bus.req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drop2");

        // Owner 2 drops while its timer reads 2.
        bus.req = 4'b0100;
        cycle("own2_a");
        cycle("own2_b");
        bus.req = 4'b0000;
        cycle("own2_drop");
        check("own2_drop.g", 32'(bus.gnt), 32'h0);
        check("own2_drop.h", 32'(bus.hex_out), 32'h0);

        bus.req = 4'b1000;
        cycle("own3_a");
        cycle("own3_b");
        bus.req = 4'b1001;
        cycle("prio0");
        check("prio0.g", 32'(bus.gnt), PRIO0 ? 32'h1 : 32'h8);
        for (int i = 0; i < 8; i++) cycle("prio0_run");
        bus.req = 4'b0000;
        for (int i = 0; i < 2; i++) cycle("drop3");

        // Reset mid-HOLD takes effect without a clock edge.
        bus.req = 4'b0010;
        cycle("pre_rst_a");
        cycle("pre_rst_b");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 4'b0000;
        cycle("post_rst");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.val_in = {$urandom, $urandom};
            bus.dp_in  = 16'($urandom);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
